// File: rtl/cpc_ram1m_pkg.sv
// Shared definitions for the CPC 1MB RAM expansion controller:
// capture FSM encoding, memory-map mode codes and config-port match bits.
package cpc_ram1m_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } cap_state_t;

  localparam logic [2:0] MODE_C0 = 3'd0;
  localparam logic [2:0] MODE_C1 = 3'd1;
  localparam logic [2:0] MODE_C2 = 3'd2;
  localparam logic [2:0] MODE_C3 = 3'd3;
  localparam logic [2:0] MODE_C4 = 3'd4;
  localparam logic [2:0] MODE_C5 = 3'd5;
  localparam logic [2:0] MODE_C6 = 3'd6;
  localparam logic [2:0] MODE_C7 = 3'd7;

  // D[7:6] pattern that marks a write to the memory-configuration port
  localparam logic [1:0] CFG_MATCH = 2'b11;

endpackage

// File: rtl/cpc_ram1m_cfgreg.sv
// Config-port capture FSM and the mode/bank register it loads,
// one capture per Z80 I/O write cycle.
module cpc_ram1m_cfgreg
  import cpc_ram1m_pkg::*;
#(
  parameter int EXT_A8_EN = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a15,
  input  logic       a14,
  input  logic       a8,
  input  logic [7:0] d,
  input  logic       ioreq_b,
  input  logic       wr_b,
  input  logic       cap_en,
  output logic [2:0] mode,
  output logic [3:0] bank
);

  cap_state_t state_q, state_d;
  logic       io_wr;
  logic       capture;
  // Set by reset so a write still in flight across reset release is not taken.
  logic       block_q;

  assign io_wr = !ioreq_b && !wr_b && !a15 && a14 && (d[7:6] == CFG_MATCH);

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (io_wr && !block_q) begin
          state_d = ST_HOLD;
          capture = cap_en;
        end
      end
      ST_HOLD: begin
        if (ioreq_b || wr_b) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mode    <= MODE_C0;
      bank    <= 4'd0;
      block_q <= 1'b1;
    end else begin
      state_q <= state_d;
      block_q <= block_q && !ioreq_b && !wr_b;
      if (capture) begin
        mode <= d[2:0];
        bank <= {((EXT_A8_EN != 0) ? ~a8 : 1'b0), d[5:3]};
      end
    end
  end

endmodule

// File: rtl/cpc_ram1m_ctrl.sv
// CPC 1MB RAM expansion controller: zero-latency SRAM decode from the
// registered config and the live Z80 bus.
module cpc_ram1m_ctrl
  import cpc_ram1m_pkg::*;
#(
  parameter int EXT_A8_EN = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       A15,
  input  logic       A14,
  input  logic       A8,
  input  logic [7:0] D,
  input  logic       MREQ_B,
  input  logic       IOREQ_B,
  input  logic       RD_B,
  input  logic       WR_B,
  input  logic       RFSH_B,
  input  logic       RAMRD_B,
  input  logic [3:0] dip,
  output logic [4:0] HIADR,
  output logic       RAMCS0_B,
  output logic       RAMCS1_B,
  output logic       RAMOE_B,
  output logic       RAMWE_B,
  output logic       RAMDIS
);

  logic [2:0] mode;
  logic [3:0] bank;
  logic [1:0] w;
  logic [1:0] page;
  logic [5:0] blk;
  logic       ext;
  logic       sel;
  logic       acc;

  // Reads are qualified by the gate array's RAMRD_B, so the Z80 RD_B is not needed.
  wire unused_ok = &{1'b0, RD_B, dip[3:2]};

  cpc_ram1m_cfgreg #(.EXT_A8_EN(EXT_A8_EN)) u_cfgreg (
    .clk     (CLK),
    .reset   (RESET),
    .a15     (A15),
    .a14     (A14),
    .a8      (A8),
    .d       (D),
    .ioreq_b (IOREQ_B),
    .wr_b    (WR_B),
    .cap_en  (dip[0]),
    .mode    (mode),
    .bank    (bank)
  );

  assign w = {A15, A14};

  always_comb begin
    ext  = 1'b0;
    page = 2'd0;
    case (mode)
      MODE_C1, MODE_C3: begin
        if (w == 2'b11) begin
          ext  = 1'b1;
          page = 2'd3;
        end
      end
      MODE_C2: begin
        ext  = 1'b1;
        page = w;
      end
      MODE_C4, MODE_C5, MODE_C6, MODE_C7: begin
        if (w == 2'b01) begin
          ext  = 1'b1;
          page = mode[1:0];
        end
      end
      default: ;
    endcase
  end

  assign blk = {bank, page};
  // On a 6128 bank 0 is the internal second 64K, so the expansion stays off it.
  assign sel = dip[0] && ext && !(dip[1] && (bank == 4'd0));
  assign acc = sel && !MREQ_B && RFSH_B;

  assign HIADR    = sel ? blk[4:0] : 5'h00;
  assign RAMDIS   = acc;
  assign RAMCS0_B = !(acc && !blk[5]);
  assign RAMCS1_B = !(acc && blk[5]);
  assign RAMWE_B  = !(acc && !WR_B);
  // A write takes priority so OE and WE are never low together.
  assign RAMOE_B  = !(acc && !RAMRD_B && WR_B);

endmodule

// File: tb/tb_cpc_ram1m_ctrl.sv
// Directed self-checking bench for cpc_ram1m_ctrl; a second instance
// with EXT_A8_EN=0 shares the bus to check 512K bank folding.
module tb_cpc_ram1m_ctrl;

  logic       clk = 1'b0;
  logic       RESET, A15, A14, A8;
  logic [7:0] D;
  logic       MREQ_B, IOREQ_B, RD_B, WR_B, RFSH_B, RAMRD_B;
  logic [3:0] dip;

  logic [4:0] hiadr_a, hiadr_b;
  logic       cs0_a, cs1_a, oe_a, we_a, dis_a;
  logic       cs0_b, cs1_b, oe_b, we_b, dis_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Observation word: {RAMDIS, RAMCS1_B, RAMCS0_B, RAMWE_B, RAMOE_B, HIADR}
  wire [9:0] obs_a = {dis_a, cs1_a, cs0_a, we_a, oe_a, hiadr_a};
  wire [9:0] obs_b = {dis_b, cs1_b, cs0_b, we_b, oe_b, hiadr_b};

  localparam logic [9:0] NO_HIT = 10'b0_1111_00000;

  always #5 clk = ~clk;

  cpc_ram1m_ctrl #(.EXT_A8_EN(1)) u_dut (
    .CLK(clk), .RESET(RESET), .A15(A15), .A14(A14), .A8(A8), .D(D),
    .MREQ_B(MREQ_B), .IOREQ_B(IOREQ_B), .RD_B(RD_B), .WR_B(WR_B),
    .RFSH_B(RFSH_B), .RAMRD_B(RAMRD_B), .dip(dip),
    .HIADR(hiadr_a), .RAMCS0_B(cs0_a), .RAMCS1_B(cs1_a),
    .RAMOE_B(oe_a), .RAMWE_B(we_a), .RAMDIS(dis_a)
  );

  cpc_ram1m_ctrl #(.EXT_A8_EN(0)) u_dut512 (
    .CLK(clk), .RESET(RESET), .A15(A15), .A14(A14), .A8(A8), .D(D),
    .MREQ_B(MREQ_B), .IOREQ_B(IOREQ_B), .RD_B(RD_B), .WR_B(WR_B),
    .RFSH_B(RFSH_B), .RAMRD_B(RAMRD_B), .dip(dip),
    .HIADR(hiadr_b), .RAMCS0_B(cs0_b), .RAMCS1_B(cs1_b),
    .RAMOE_B(oe_b), .RAMWE_B(we_b), .RAMDIS(dis_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    MREQ_B = 1'b1; IOREQ_B = 1'b1; RD_B = 1'b1; WR_B = 1'b1;
    RFSH_B = 1'b1; RAMRD_B = 1'b1;
    #1;
  endtask

  task automatic mem(input logic [1:0] w, input logic rd, input logic wr);
    A15 = w[1]; A14 = w[0];
    MREQ_B = 1'b0; RD_B = !rd; RAMRD_B = !rd; WR_B = !wr;
    #1;
  endtask

  task automatic io_out(input logic [7:0] d, input logic a8);
    A15 = 1'b0; A14 = 1'b1; A8 = a8; D = d;
    IOREQ_B = 1'b0; WR_B = 1'b0;
    @(posedge clk); #1;
    IOREQ_B = 1'b1; WR_B = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    RESET = 1'b1; A15 = 1'b0; A14 = 1'b0; A8 = 1'b0; D = 8'h00; dip = 4'b0001;
    bus_idle();
    repeat (3) @(posedge clk);
    #1;

    // Reset state with a read in the top window
    mem(2'b11, 1'b1, 1'b0);
    check("rst_rd", obs_a, NO_HIT);
    @(posedge clk); #1;
    RESET = 1'b0;
    bus_idle();
    @(posedge clk); #1;
    mem(2'b11, 1'b1, 1'b0);
    check("rst_rel_rd", obs_a, NO_HIT);
    bus_idle();

    // OUT &7FC1: mode 1, bank 0
    io_out(8'hC1, 1'b1);
    mem(2'b11, 1'b1, 1'b0);
    check("m1_rd_c000", obs_a, {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'b00011});
    RAMRD_B = 1'b1; #1;
    check("m1_oe_follow", obs_a, {1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'b00011});
    bus_idle();
    mem(2'b10, 1'b1, 1'b0);
    check("m1_w2_nohit", obs_a, NO_HIT);
    bus_idle();

    // OUT &7EFE: mode 6, bank 15 (bank 7 when A8 extension disabled)
    io_out(8'hFE, 1'b0);
    mem(2'b01, 1'b0, 1'b1);
    check("m6_wr_4000", obs_a, {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'b11110});
    check("m6_wr_512k", obs_b, {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'b11110});
    RAMRD_B = 1'b0; #1;
    check("we_beats_oe", obs_a, {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'b11110});
    bus_idle();
    mem(2'b00, 1'b1, 1'b0);
    check("m6_w0_nohit", obs_a, NO_HIT);
    bus_idle();

    // 6128 host: bank 0 stays internal, bank 1 maps
    dip = 4'b0011;
    io_out(8'hC2, 1'b1);
    for (int i = 0; i < 4; i++) begin
      mem(i[1:0], 1'b1, 1'b0);
      check($sformatf("b0_6128_w%0d", i), obs_a, NO_HIT);
      bus_idle();
    end
    io_out(8'hCA, 1'b1);
    mem(2'b10, 1'b1, 1'b0);
    check("b1_6128_w2", obs_a, {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'b00110});
    bus_idle();

    // Long write: only the first value is captured
    dip = 4'b0001;
    A15 = 1'b0; A14 = 1'b1; A8 = 1'b1; D = 8'hC1;
    IOREQ_B = 1'b0; WR_B = 1'b0;
    @(posedge clk); #1;
    D = 8'hC2;
    repeat (4) @(posedge clk);
    #1;
    IOREQ_B = 1'b1; WR_B = 1'b1;
    @(posedge clk); #1;
    mem(2'b11, 1'b1, 1'b0);
    check("long_wr_w3", obs_a, {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'b00011});
    bus_idle();
    mem(2'b10, 1'b1, 1'b0);
    check("long_wr_w2", obs_a, NO_HIT);
    bus_idle();

    // Reset in HOLD: config cleared, no recapture while the write is still low
    A15 = 1'b0; A14 = 1'b1; A8 = 1'b1; D = 8'hC5;
    IOREQ_B = 1'b0; WR_B = 1'b0;
    @(posedge clk); #1;
    RESET = 1'b1;
    @(posedge clk); #1;
    RESET = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    IOREQ_B = 1'b1; WR_B = 1'b1;
    @(posedge clk); #1;
    mem(2'b01, 1'b1, 1'b0);
    check("rst_hold_w1", obs_a, NO_HIT);
    bus_idle();
    mem(2'b11, 1'b1, 1'b0);
    check("rst_hold_w3", obs_a, NO_HIT);
    bus_idle();
    io_out(8'hC5, 1'b1);
    mem(2'b01, 1'b1, 1'b0);
    check("rearm_m5_w1", obs_a, {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'b00001});
    bus_idle();

    // Mode 2 with refresh
    io_out(8'hC2, 1'b1);
    mem(2'b00, 1'b1, 1'b0);
    RFSH_B = 1'b0; #1;
    check("rfsh_quiet", obs_a, NO_HIT);
    RFSH_B = 1'b1; #1;
    check("m2_w0_rd", obs_a, {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'b00000});
    bus_idle();

    // Expansion disabled: capture ignored, config kept
    dip = 4'b0000;
    io_out(8'hC7, 1'b1);
    mem(2'b01, 1'b1, 1'b0);
    check("dis_nohit", obs_a, NO_HIT);
    bus_idle();
    dip = 4'b0001;
    mem(2'b01, 1'b1, 1'b0);
    check("dis_cfg_kept", obs_a, {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'b00001});
    bus_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpc_ram1m_ctrl.md
CPC_RAM1M_CTRL -- requirements
Module: cpc_ram1m_ctrl

Interface
REQ-001 SHALL have parameter: EXT_A8_EN, default 1, meaning: inverted A8 at config write forms bank bit 3 (1MB); 0 forces bank bit 3 = 0 (512K).
REQ-002 SHALL have ports, one per line:
- CLK  in  1  CPC bus clock; the block's only clock.
- RESET  in  1  reset; synchronous, active-high.
- A15, A14, A8  in  1 each  Z80 address bits.
- D  in  8  Z80 data bus; input only.
- MREQ_B, IOREQ_B, RD_B, WR_B, RFSH_B  in  1 each  Z80 strobes; active-low.
- RAMRD_B  in  1  gate-array RAM read strobe; active-low.
- dip  in  4  DIP switches: dip[0] = expansion enable; dip[1] = host is 6128; dip[3:2] reserved.
- HIADR  out  5  SRAM address bits 18:14.
- RAMCS0_B, RAMCS1_B  out  1 each  SRAM chip selects, 512K each; active-low.
- RAMOE_B, RAMWE_B  out  1 each  SRAM output enable and write enable; active-low.
- RAMDIS  out  1  disables internal CPC RAM; active-high.

Function
REQ-003 Config write detect: io_wr = !IOREQ_B & !WR_B & !A15 & A14 & D[7] & D[6], sampled on CLK rising edge.
REQ-004 Capture FSM states:
- IDLE: on io_wr, go to HOLD and capture.
- HOLD: return to IDLE when IOREQ_B or WR_B is sampled high.
- Exactly one capture per I/O cycle, however long WR_B is held low.
REQ-005 Capture SHALL load:
- mode[2:0] = D[2:0]
- bank[3:0] = {EXT_A8_EN ? ~A8 : 0, D[5:3]}
The new config governs memory decode from the cycle after the capture edge.
REQ-006 Captures SHALL be ignored while dip[0] = 0; the config register holds its value.
REQ-007 Window w = {A15, A14}. Expansion hit (ext) by mode:
- 0: none.
- 1: w=3 to page 3.
- 2: w=0..3 to pages 0..3.
- 3: w=3 to page 3.
- 4..7: w=1 to page (mode-4).
REQ-008 blk[5:0] = {bank, page}; HIADR = blk[4:0]; blk[5] selects RAMCS1_B, else RAMCS0_B.
REQ-009 sel SHALL be 0 in each of these cases:
- dip[0] = 0
- ext = 0
- dip[1] = 1 and bank = 0 (6128 internal second 64K)
REQ-010 Decode SHALL be combinational from the registered config and live bus (zero latency), with acc = sel & !MREQ_B & RFSH_B.
- RAMDIS = acc
- RAMWE_B = !(acc & !WR_B)
- RAMOE_B = !(acc & !RAMRD_B)
- active CS_B = !acc
REQ-011 During refresh (RFSH_B = 0) all strobes SHALL be inactive and RAMDIS = 0.
REQ-012 RAMWE_B and RAMOE_B SHALL never be low simultaneously; if WR_B and RAMRD_B are both low, WE wins and OE stays high.
REQ-013 HIADR SHALL be driven whenever sel = 1 and SHALL be 5'h00 when sel = 0.

Reset
REQ-014 While RESET = 1 at a CLK edge, the following SHALL hold:
- FSM = IDLE
- mode = 0
- bank = 0
- hence RAMDIS = 0, all _B outputs = 1, HIADR = 0
REQ-015 RESET during HOLD SHALL abort the capture; the same still-active write SHALL NOT be captured after reset release until IOREQ_B or WR_B deasserts.

Structure
REQ-016 Shared package cpc_ram1m_pkg SHALL hold the FSM state encoding, the mode constants (MODE_C0..MODE_C7) and the config port match bits (D[7:6] = 2'b11).
REQ-017 Sub-module cpc_ram1m_cfgreg SHALL contain the capture FSM and config register; the top level SHALL contain the decode logic only.

Verification
REQ-018 Reset, then MREQ_B=0, RD_B=0, A15:A14=2'b11, dip=4'b0001 -> RAMDIS=0, RAMCS0_B=RAMCS1_B=1, HIADR=0.
REQ-019 OUT &7FC1 (D=8'hC1, A8=1), then read &C000 -> RAMCS0_B=0, HIADR=5'b00011, RAMDIS=1, RAMOE_B follows RAMRD_B.
REQ-020 OUT &7EFE (D=8'hFE, A8=0, mode 6, bank 15), then write &4000 -> RAMCS1_B=0, HIADR=5'b11110, RAMWE_B=0; repeat with EXT_A8_EN=0 -> RAMCS0_B=0.
REQ-021 dip=4'b0011, OUT D=8'hC2 with A8=1 -> sel=0 on every window; change to D=8'hCA -> bank 1, w=2 gives HIADR=5'b00110.
REQ-022 WR_B held low for 5 CLKs while D changes C1 to C2 -> only C1 captured; RESET asserted mid-HOLD -> config 0, no recapture until WR_B rises.
REQ-023 Mode 2 active, RFSH_B=0 with MREQ_B=0 -> all strobes high, RAMDIS=0; dip[0]=0 then OUT &7FC7 -> config unchanged.
